// File: rtl/vga_green_centroid.sv
// ---------------------------------------------------------------------------
// vga_green_centroid
// Receives the VGA pixel stream (DE/VS/RGB in the pixel clock domain),
// rebuilds pixel coordinates, classifies active pixels as "green" and
// accumulates a per-frame centroid of the green pixels. Once per frame the
// centroid is divided out serially and published as a cursor position.
//
// Ports
//   clk        in   pixel clock
//   rst        in   synchronous, active-high reset
//   de         in   data enable, high = active pixel
//   vs         in   vertical sync, active-low
//   red        in   [7:0] pixel red   (valid when de=1)
//   green      in   [7:0] pixel green (valid when de=1)
//   blue       in   [7:0] pixel blue  (valid when de=1)
//   x_pos      out  [9:0] centroid column, 0..H_ACTIVE-1
//   y_pos      out  [8:0] centroid row, 0..V_ACTIVE-1
//   valid      out  last published frame had >= MIN_PIXELS green pixels
//   pix_count  out  [18:0] green-pixel count of last published frame
//   frame_done out  one-cycle pulse when the outputs update
//   line_err   out  sticky: some line had a DE length != H_ACTIVE
// ---------------------------------------------------------------------------
module vga_green_centroid #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned G_MIN      = 128,
    parameter int unsigned MARGIN     = 32,
    parameter int unsigned MIN_PIXELS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        de,
    input  logic        vs,
    input  logic [7:0]  red,
    input  logic [7:0]  green,
    input  logic [7:0]  blue,
    output logic [9:0]  x_pos,
    output logic [8:0]  y_pos,
    output logic        valid,
    output logic [18:0] pix_count,
    output logic        frame_done,
    output logic        line_err
);

    localparam logic [9:0]  X_MAX   = 10'(H_ACTIVE - 1);
    localparam logic [8:0]  Y_MAX   = 9'(V_ACTIVE - 1);
    localparam logic [11:0] H_LEN   = 12'(H_ACTIVE);
    localparam logic [8:0]  G_MIN9  = 9'(G_MIN);
    localparam logic [8:0]  MARGIN9 = 9'(MARGIN);
    localparam logic [18:0] MIN_CNT = 19'(MIN_PIXELS);

    typedef enum logic [1:0] {
        ACCUM,
        DIV_X,
        DIV_Y,
        PUBLISH
    } state_t;

    state_t      state;

    // Stream tracking
    logic        vs_prev;
    logic        de_prev;
    logic        frame_end;
    logic [11:0] len;
    logic [8:0]  y;
    logic [9:0]  x_cur;
    logic        de_fall;
    logic        pixel_green;

    // Live accumulators
    logic [27:0] sum_x;
    logic [27:0] sum_y;
    logic [18:0] cnt;

    // Divider
    logic [27:0] snap_y;
    logic [18:0] snap_cnt;
    logic [27:0] dvd;
    logic [18:0] rem;
    logic [27:0] quo;
    logic [4:0]  bit_cnt;
    logic [9:0]  qx;

    logic [19:0] trial;
    logic        ge;
    logic [18:0] rem_nx;
    logic [27:0] quo_nx;
    logic        div_en;
    logic [9:0]  x_clip;
    logic [8:0]  y_clip;

    // x counts DE-high cycles in the line; len keeps counting past the
    // active width so that an over-long line is still detectable.
    always_comb begin
        x_cur = (len >= {2'b00, X_MAX}) ? X_MAX : len[9:0];
        de_fall = de_prev & ~de;
        // 9-bit compares so red/blue + MARGIN cannot wrap
        pixel_green = de & vs
                    & ({1'b0, green} >= G_MIN9)
                    & ({1'b0, green} > ({1'b0, red}  + MARGIN9))
                    & ({1'b0, green} > ({1'b0, blue} + MARGIN9));
    end

    // One restoring-division step: shift in the next dividend bit and
    // subtract the count if it fits.
    always_comb begin
        trial  = {rem, dvd[27]};
        ge     = trial >= {1'b0, snap_cnt};
        rem_nx = 19'(ge ? (trial - {1'b0, snap_cnt}) : trial);
        quo_nx = {quo[26:0], ge};
        div_en = snap_cnt != '0;
        x_clip = (quo_nx > {18'b0, X_MAX}) ? X_MAX : quo_nx[9:0];
        y_clip = (quo > {19'b0, Y_MAX}) ? Y_MAX : quo[8:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_prev   <= 1'b0;
            de_prev   <= 1'b0;
            frame_end <= 1'b0;
            len       <= '0;
            y         <= '0;
            line_err  <= 1'b0;
            sum_x     <= '0;
            sum_y     <= '0;
            cnt       <= '0;
        end else begin
            vs_prev   <= vs;
            de_prev   <= de;
            frame_end <= vs_prev & ~vs;

            if (de) begin
                if (len != '1) begin
                    len <= len + 12'd1;
                end
            end else if (de_fall) begin
                len <= '0;
            end

            if (de_fall && (len != H_LEN)) begin
                line_err <= 1'b1;
            end

            if (frame_end) begin
                y <= '0;
            end else if (de_fall && (y != Y_MAX)) begin
                y <= y + 9'd1;
            end

            // The divider snapshots these on frame_end, so clearing here
            // starts the next frame without losing the finished one.
            if (frame_end) begin
                sum_x <= '0;
                sum_y <= '0;
                cnt   <= '0;
            end else if (pixel_green) begin
                sum_x <= sum_x + {18'b0, x_cur};
                sum_y <= sum_y + {19'b0, y};
                cnt   <= cnt + 19'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ACCUM;
            snap_y     <= '0;
            snap_cnt   <= '0;
            dvd        <= '0;
            rem        <= '0;
            quo        <= '0;
            bit_cnt    <= '0;
            qx         <= '0;
            x_pos      <= '0;
            y_pos      <= '0;
            valid      <= 1'b0;
            pix_count  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (state == PUBLISH) begin
                frame_done <= 1'b1;
                pix_count  <= snap_cnt;
                if (snap_cnt >= MIN_CNT) begin
                    x_pos <= qx;
                    y_pos <= y_clip;
                    valid <= 1'b1;
                end else begin
                    valid <= 1'b0;
                end
            end

            // A new frame end always wins: any division in flight is dropped
            // and restarted on the fresh snapshot.
            if (frame_end) begin
                dvd      <= sum_x;
                snap_y   <= sum_y;
                snap_cnt <= cnt;
                rem      <= '0;
                quo      <= '0;
                bit_cnt  <= '0;
                state    <= DIV_X;
            end else begin
                case (state)
                    ACCUM: begin
                        state <= ACCUM;
                    end
                    DIV_X: begin
                        if (div_en) begin
                            rem <= rem_nx;
                            quo <= quo_nx;
                            dvd <= {dvd[26:0], 1'b0};
                        end
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd27) begin
                            qx      <= x_clip;
                            dvd     <= snap_y;
                            rem     <= '0;
                            quo     <= '0;
                            bit_cnt <= '0;
                            state   <= DIV_Y;
                        end
                    end
                    DIV_Y: begin
                        if (div_en) begin
                            rem <= rem_nx;
                            quo <= quo_nx;
                            dvd <= {dvd[26:0], 1'b0};
                        end
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd27) begin
                            bit_cnt <= '0;
                            state   <= PUBLISH;
                        end
                    end
                    PUBLISH: begin
                        state <= ACCUM;
                    end
                    default: begin
                        state <= ACCUM;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_green_centroid.sv
// ---------------------------------------------------------------------------
// tb_vga_green_centroid
// Scoreboard bench for vga_green_centroid using a reduced 16x12 geometry.
// Each frame end pushes the hand-computed publish result; a monitor pops and
// compares on every frame_done pulse.
// ---------------------------------------------------------------------------
module tb_vga_green_centroid;

    logic        clk = 1'b0;
    logic        rst;
    logic        de;
    logic        vs;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic [9:0]  x_pos;
    logic [8:0]  y_pos;
    logic        valid;
    logic [18:0] pix_count;
    logic        frame_done;
    logic        line_err;

    vga_green_centroid #(
        .H_ACTIVE(16),
        .V_ACTIVE(12)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .de        (de),
        .vs        (vs),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .valid     (valid),
        .pix_count (pix_count),
        .frame_done(frame_done),
        .line_err  (line_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int at;
        int x;
        int y;
        int cnt;
        int vld;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // {red, green, blue} indexed by line and DE-cycle index
    logic [23:0] img [0:15][0:23];
    localparam logic [23:0] GRN = {8'd50, 8'd200, 8'd50};

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_img();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 24; c++)
                img[r][c] = '0;
    endtask

    task automatic square_img();
        clear_img();
        for (int r = 2; r <= 9; r++)
            for (int c = 4; c <= 11; c++)
                img[r][c] = GRN;
    endtask

    task automatic drive_line(input int row, input int len);
        for (int i = 0; i < len; i++) begin
            step();
            de = 1'b1;
            {red, green, blue} = img[row][i];
        end
        step();
        de = 1'b0;
        {red, green, blue} = '0;
        step();
    endtask

    task automatic drive_lines(input int n, input int len);
        for (int r = 0; r < n; r++) drive_line(r, len);
    endtask

    task automatic vs_fall_push(input int x, input int y, input int cnt, input int vld);
        step();
        vs = 1'b0;
        sb.push_back('{int'(cyc) + 59, x, y, cnt, vld});
        step();
        step();
        step();
        vs = 1'b1;
        step();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_x_pos"}, int'(x_pos), 0);
        chk({tag, "_y_pos"}, int'(y_pos), 0);
        chk({tag, "_valid"}, int'(valid), 0);
        chk({tag, "_pix_count"}, int'(pix_count), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_line_err"}, int'(line_err), 0);
    endtask

    always @(negedge clk) begin
        if (frame_done) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_frame_done: pulse at cycle %0d, expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("done_cycle", int'(cyc), mon_e.at);
                chk("x_pos", int'(x_pos), mon_e.x);
                chk("y_pos", int'(y_pos), mon_e.y);
                chk("pix_count", int'(pix_count), mon_e.cnt);
                chk("valid", int'(valid), mon_e.vld);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int unsigned c1;

    initial begin
        rst = 1'b1;
        de  = 1'b0;
        vs  = 1'b1;
        {red, green, blue} = '0;
        repeat (3) step();
        chk_outputs_zero("reset");
        rst = 1'b0;
        step();

        // T1: partial frame with greens, reset mid-stream while vs falls
        clear_img();
        for (int c = 0; c < 16; c++) begin
            img[0][c] = GRN;
            img[1][c] = GRN;
        end
        drive_lines(2, 16);
        step();
        rst = 1'b1;
        vs  = 1'b0;
        repeat (3) step();
        step();
        rst = 1'b0;
        step();
        vs = 1'b1;
        step();
        chk_outputs_zero("midreset");

        // T2: 8x8 square at x 4..11, y 2..9 -> centroid (7,5)
        square_img();
        drive_lines(12, 16);
        vs_fall_push(7, 5, 64, 1);

        // T3: 63 greens -> invalid, position held
        clear_img();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 16; c++)
                img[r][c] = GRN;
        for (int c = 0; c < 15; c++) img[3][c] = GRN;
        drive_lines(12, 16);
        vs_fall_push(7, 5, 63, 0);

        // T4: thresholds; only the first pixel qualifies
        clear_img();
        img[0][0] = {8'd95,  8'd128, 8'd95};
        img[0][1] = {8'd96,  8'd128, 8'd0};
        img[0][2] = {8'd0,   8'd127, 8'd0};
        img[0][3] = {8'd250, 8'd255, 8'd0};
        img[0][4] = {8'd0,   8'd200, 8'd168};
        drive_lines(12, 16);
        vs_fall_push(7, 5, 1, 0);

        // T6a: second frame end 20 cycles after the first aborts it
        square_img();
        drive_lines(12, 16);
        clear_img();
        for (int c = 0; c < 5; c++) img[0][c] = GRN;
        step();
        vs = 1'b0;
        c1 = cyc;
        step();
        step();
        step();
        vs = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            de = 1'b1;
            {red, green, blue} = img[0][i];
        end
        step();
        de = 1'b0;
        {red, green, blue} = '0;
        vs = 1'b0;
        sb.push_back('{int'(c1) + 20 + 59, 7, 5, 5, 0});
        step();
        step();
        step();
        vs = 1'b1;
        repeat (70) step();

        // T6b: reset during division -> no pulse, outputs cleared
        square_img();
        drive_lines(12, 16);
        step();
        vs = 1'b0;
        c1 = cyc;
        step();
        step();
        step();
        vs = 1'b1;
        while (cyc < c1 + 31) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (70) step();
        chk_outputs_zero("divreset");

        // T5: short line sets line_err; long lines saturate x at 15
        clear_img();
        for (int r = 1; r <= 8; r++) begin
            for (int c = 0; c < 4; c++)   img[r][c] = GRN;
            for (int c = 16; c < 20; c++) img[r][c] = GRN;
        end
        drive_line(0, 15);
        step();
        chk("line_err_short", int'(line_err), 1);
        for (int r = 1; r <= 8; r++) drive_line(r, 20);
        for (int r = 9; r < 12; r++) drive_line(r, 16);
        vs_fall_push(8, 4, 64, 1);
        repeat (70) step();
        chk("line_err_sticky", int'(line_err), 1);
        chk("pending_frames", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
